fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, fetch address after reset; SHALL be word-aligned.
REQ-002 Port clk_i  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 Port imem_req_o  output  1  instruction memory request.
REQ-005 Port imem_addr_o  output  32  request byte address.
REQ-006 Port imem_ack_i  input  1  memory response valid; data valid in the same cycle.
REQ-007 Port imem_rdata_i  input  32  instruction word returned with ack.
REQ-008 Port stall_i  input  1  downstream not ready to consume instr_o.
REQ-009 Port branch_i  input  1  branch flag from control decode of the presented instruction.
REQ-010 Port zero_i  input  1  ALU zero flag for the presented instruction.
REQ-011 Port branch_target_i  input  32  branch destination address.
REQ-012 Port instr_valid_o  output  1  instr_o, opcode_o and pc_o are valid.
REQ-013 Port instr_o  output  32  fetched instruction word, registered.
REQ-014 Port opcode_o  output  7  instr_o[6:0], feeds control opcode_i.
REQ-015 Port pc_o  output  32  address instr_o was fetched from.
REQ-016 Port error_o  output  1  sticky misaligned-branch-target flag.

Function
REQ-017 Internal fetch_pc register SHALL hold the next fetch address; states SHALL be IDLE, REQ, HOLD, HALT.
REQ-018 IDLE: req 0, valid 0; SHALL go to REQ unconditionally next cycle.
REQ-019 REQ: imem_req_o=1, imem_addr_o=fetch_pc; req and addr SHALL stay constant until imem_ack_i (one outstanding request only, never withdrawn).
REQ-020 REQ with imem_ack_i=1: next cycle instr_o=imem_rdata_i, pc_o=fetch_pc, instr_valid_o=1, fetch_pc=fetch_pc+4, state HOLD.
REQ-021 fetch_pc increment SHALL be modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000).
REQ-022 HOLD: imem_req_o=0, instr_valid_o=1, outputs stable while stall_i=1.
REQ-023 HOLD with stall_i=0 (consume): next cycle instr_valid_o=0 and state REQ.
REQ-024 On consume with branch_i=1 and zero_i=1, fetch_pc SHALL load branch_target_i instead of keeping pc_o+4.
REQ-025 On consume with branch taken and branch_target_i[1:0]!=0: error_o=1, instr_valid_o=0, state HALT; fetch_pc unchanged.
REQ-026 branch_i/zero_i SHALL be ignored outside the consume cycle.
REQ-027 HALT: req 0, valid 0, error_o 1; SHALL persist until reset.
REQ-028 imem_ack_i in IDLE, HOLD or HALT SHALL be ignored.
REQ-029 opcode_o SHALL equal instr_o[6:0] combinationally at all times.
REQ-030 Throughput: one instruction per 2 cycles minimum (ack same cycle as request, no stall).

Reset
REQ-031 rst_ni=0 SHALL immediately force state IDLE, fetch_pc=RESET_PC, imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, pc_o=0, error_o=0.
REQ-032 Reset asserted mid-request SHALL abandon it; a late ack after release SHALL be dropped (IDLE).

Verification
REQ-033 Reset release, RESET_PC=0 -> cycle 1 req=0; cycle 2 req=1 addr=0; ack rdata=32'h0000_0033 -> next cycle valid=1, instr_o=32'h33, opcode_o=7'b0110011, pc_o=0.
REQ-034 Stall: stall_i=1 for 3 cycles in HOLD -> instr_o/pc_o stable, req=0; release -> next cycle valid=0, req=1, addr=4.
REQ-035 Branch: presented instr with branch_i=1, zero_i=1, target=32'h40 -> next addr=32'h40; same with zero_i=0 -> addr=pc_o+4.
REQ-036 Misaligned: taken branch target=32'h42 -> error_o=1, req=0 and valid=0 held 10+ cycles until rst_ni=0.
REQ-037 Wrap: RESET_PC=32'hFFFF_FFFC, ack, consume -> second request addr=32'h0000_0000.
REQ-038 Reset mid-REQ: rst_ni=0 while req=1 -> req=0, valid=0 same cycle; ack in first cycle after release -> no valid, second request addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-fetch bus: memory handshake, downstream stall/branch feedback,
// and the presented instruction.
interface fetch_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        stall_i;
    logic        branch_i;
    logic        zero_i;
    logic [31:0] branch_target_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [6:0]  opcode_o;
    logic [31:0] pc_o;
    logic        error_o;

    modport master (
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, opcode_o, pc_o, error_o,
        input  imem_ack_i, imem_rdata_i, stall_i, branch_i, zero_i, branch_target_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, opcode_o, pc_o, error_o,
        output imem_ack_i, imem_rdata_i, stall_i, branch_i, zero_i, branch_target_i
    );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: request, hold the word until consumed,
// redirect on taken branches, halt on a misaligned branch target.
//
// state | meaning
// IDLE  | one quiet cycle after reset
// REQ   | request at fetch_pc, waiting for ack
// HOLD  | instruction presented, waiting for consume (stall_i=0)
// HALT  | misaligned taken branch seen, frozen until reset
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic    clk_i,
    input logic    rst_ni,
    fetch_if.master bus
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic        error_q;
    logic        take_ack;
    logic        consume;
    logic        taken;
    logic        misaligned;

    assign taken      = bus.branch_i && bus.zero_i;
    assign misaligned = (bus.branch_target_i[1:0] != 2'b00);

    always_comb begin
        state_d  = state_q;
        take_ack = 1'b0;
        consume  = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (bus.imem_ack_i) begin
                    take_ack = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (!bus.stall_i) begin
                    consume = 1'b1;
                    state_d = (taken && misaligned) ? HALT : REQ;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            instr_q    <= 32'h0;
            pc_q       <= 32'h0;
            error_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take_ack) begin
                instr_q    <= bus.imem_rdata_i;
                pc_q       <= fetch_pc_q;
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end
            // A misaligned target leaves fetch_pc pointing at the fall-through address.
            if (consume && taken) begin
                if (misaligned) error_q    <= 1'b1;
                else            fetch_pc_q <= bus.branch_target_i;
            end
        end
    end

    assign bus.imem_req_o    = (state_q == REQ);
    assign bus.imem_addr_o   = fetch_pc_q;
    assign bus.instr_valid_o = (state_q == HOLD);
    assign bus.instr_o       = instr_q;
    assign bus.opcode_o      = instr_q[6:0];
    assign bus.pc_o          = pc_q;
    assign bus.error_o       = error_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand sequences for halt, wrap and
// mid-request reset, then random traffic against a behavioural model.
module tb_fetch_unit;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    fetch_if bus0();
    fetch_if bus1();

    fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(bus0.master));
    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(bus1.master));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        stall;
        logic        br;
        logic        zr;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[14];

    // behavioural model of the fetch sequence
    logic [31:0] m_next, m_instr, m_pc;
    bit          m_have, m_halt, m_fresh;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic ack, input logic [31:0] rdata, input logic stall,
                          input logic br, input logic zr, input logic [31:0] tgt);
        bus0.imem_ack_i      = ack;
        bus0.imem_rdata_i    = rdata;
        bus0.stall_i         = stall;
        bus0.branch_i        = br;
        bus0.zero_i          = zr;
        bus0.branch_target_i = tgt;
    endtask

    task automatic model_reset();
        m_next  = 32'h0;
        m_instr = 32'h0;
        m_pc    = 32'h0;
        m_have  = 0;
        m_halt  = 0;
        m_fresh = 1;
    endtask

    task automatic model_step();
        if (m_halt) begin
        end else if (m_fresh) begin
            m_fresh = 0;
        end else if (!m_have) begin
            if (bus0.imem_ack_i) begin
                m_have  = 1;
                m_instr = bus0.imem_rdata_i;
                m_pc    = m_next;
                m_next  = m_next + 32'd4;
            end
        end else if (!bus0.stall_i) begin
            m_have = 0;
            if (bus0.branch_i && bus0.zero_i) begin
                if (bus0.branch_target_i[1:0] != 2'b00) m_halt = 1;
                else m_next = bus0.branch_target_i;
            end
        end
    endtask

    task automatic model_check();
        chk("rnd_req",    bus0.imem_req_o,    {31'h0, !m_halt && !m_fresh && !m_have});
        chk("rnd_addr",   bus0.imem_addr_o,   m_next);
        chk("rnd_valid",  bus0.instr_valid_o, {31'h0, m_have});
        chk("rnd_instr",  bus0.instr_o,       m_instr);
        chk("rnd_opcode", bus0.opcode_o,      {25'h0, m_instr[6:0]});
        chk("rnd_pc",     bus0.pc_o,          m_pc);
        chk("rnd_error",  bus0.error_o,       {31'h0, m_halt});
    endtask

    initial begin
        logic [31:0] t;
        int          halt_cnt;

        tbl[0]  = '{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h0,  32'h0};
        tbl[1]  = '{1'b1, 32'h0000_0033, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  1'b0, 32'h0,  32'h0};
        tbl[2]  = '{1'b1, 32'h1111_1111, 1'b1, 1'b1, 1'b1, 32'h80, 1'b0, 32'h4,  1'b1, 32'h33, 32'h0};
        tbl[3]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h80, 1'b0, 32'h4,  1'b1, 32'h33, 32'h0};
        tbl[4]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h4,  1'b1, 32'h33, 32'h0};
        tbl[5]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h4,  1'b1, 32'h33, 32'h0};
        tbl[6]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h4,  1'b0, 32'h33, 32'h0};
        tbl[7]  = '{1'b1, 32'h0000_0063, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h4,  1'b0, 32'h33, 32'h0};
        tbl[8]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h8,  1'b1, 32'h63, 32'h4};
        tbl[9]  = '{1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h40, 1'b0, 32'h63, 32'h4};
        tbl[10] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h80, 1'b0, 32'h44, 1'b1, 32'h13, 32'h40};
        tbl[11] = '{1'b1, 32'h0000_006F, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h44, 1'b0, 32'h13, 32'h40};
        tbl[12] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h48, 1'b1, 32'h6F, 32'h44};
        tbl[13] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h48, 1'b0, 32'h6F, 32'h44};

        drive0(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        bus1.imem_ack_i = 1'b0; bus1.imem_rdata_i = 32'h0; bus1.stall_i = 1'b0;
        bus1.branch_i = 1'b0; bus1.zero_i = 1'b0; bus1.branch_target_i = 32'h0;

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req",   bus0.imem_req_o,    32'h0);
        chk("rst_addr",  bus0.imem_addr_o,   32'h0);
        chk("rst_valid", bus0.instr_valid_o, 32'h0);
        chk("rst_instr", bus0.instr_o,       32'h0);
        chk("rst_pc",    bus0.pc_o,          32'h0);
        chk("rst_error", bus0.error_o,       32'h0);
        chk("rst_addr1", bus1.imem_addr_o,   32'hFFFF_FFFC);
        step();
        step();
        rst_n = 1'b1;

        // directed vectors: check current outputs, then apply row inputs for the next edge
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("vec%0d_req", i),    bus0.imem_req_o,    {31'h0, tbl[i].e_req});
            chk($sformatf("vec%0d_addr", i),   bus0.imem_addr_o,   tbl[i].e_addr);
            chk($sformatf("vec%0d_valid", i),  bus0.instr_valid_o, {31'h0, tbl[i].e_valid});
            chk($sformatf("vec%0d_instr", i),  bus0.instr_o,       tbl[i].e_instr);
            chk($sformatf("vec%0d_opcode", i), bus0.opcode_o,      {25'h0, tbl[i].e_instr[6:0]});
            chk($sformatf("vec%0d_pc", i),     bus0.pc_o,          tbl[i].e_pc);
            chk($sformatf("vec%0d_error", i),  bus0.error_o,       32'h0);
            drive0(tbl[i].ack, tbl[i].rdata, tbl[i].stall, tbl[i].br, tbl[i].zr, tbl[i].tgt);
            step();
        end

        // misaligned taken branch halts until reset
        drive0(1'b1, 32'h0000_0063, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("mis_valid", bus0.instr_valid_o, 32'h1);
        chk("mis_pc",    bus0.pc_o,          32'h48);
        drive0(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h42);
        step();
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("halt%0d_error", i), bus0.error_o,       32'h1);
            chk($sformatf("halt%0d_req", i),   bus0.imem_req_o,    32'h0);
            chk($sformatf("halt%0d_valid", i), bus0.instr_valid_o, 32'h0);
            chk($sformatf("halt%0d_addr", i),  bus0.imem_addr_o,   32'h4C);
            drive0(1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom), $urandom & 32'hFC);
            step();
        end
        rst_n = 1'b0;
        #1;
        chk("halt_rst_error", bus0.error_o,     32'h0);
        chk("halt_rst_addr",  bus0.imem_addr_o, 32'h0);
        drive0(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        rst_n = 1'b1;

        // wrap of fetch_pc on the second instance
        step();
        chk("wrap_req1",  bus1.imem_req_o,  32'h1);
        chk("wrap_addr1", bus1.imem_addr_o, 32'hFFFF_FFFC);
        bus1.imem_ack_i = 1'b1; bus1.imem_rdata_i = 32'h0000_0013;
        step();
        chk("wrap_valid", bus1.instr_valid_o, 32'h1);
        chk("wrap_pc",    bus1.pc_o,          32'hFFFF_FFFC);
        bus1.imem_ack_i = 1'b0;
        step();
        chk("wrap_req2",  bus1.imem_req_o,  32'h1);
        chk("wrap_addr2", bus1.imem_addr_o, 32'h0);

        // reset asserted while a request is outstanding
        chk("midreq_pre_req", bus0.imem_req_o, 32'h1);
        #3 rst_n = 1'b0;
        #1;
        chk("midreq_req",   bus0.imem_req_o,    32'h0);
        chk("midreq_valid", bus0.instr_valid_o, 32'h0);
        step();
        rst_n = 1'b1;
        drive0(1'b1, 32'h0000_0077, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("late_ack_valid", bus0.instr_valid_o, 32'h0);
        chk("late_ack_req",   bus0.imem_req_o,    32'h1);
        chk("late_ack_addr",  bus0.imem_addr_o,   32'h0);
        drive0(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("late_ack_valid2", bus0.instr_valid_o, 32'h0);

        // random traffic against the model
        rst_n = 1'b0;
        #1;
        model_reset();
        model_check();
        #1 rst_n = 1'b1;
        halt_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            t = ($urandom_range(0, 39) == 0) ? ($urandom | 32'h1) : ($urandom & 32'hFFFF_FFFC);
            drive0(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 9) < 4),
                   ($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)), t);
            model_step();
            step();
            model_check();
            if (m_halt) halt_cnt++;
            if (halt_cnt > 4) begin
                halt_cnt = 0;
                rst_n = 1'b0;
                #1;
                model_reset();
                model_check();
                #1 rst_n = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
